fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk input 1, rising-edge clock; rst input 1, asynchronous active-high reset.
REQ-002 The block SHALL have the following ports:
- start  input 1: pulse; leaves IDLE.
- mem_req  output 1: instruction-memory read request.
- mem_addr  output 64: byte address of the requested instruction, equal to pc.
- mem_ready  input 1: memory returned mem_rdata this cycle.
- mem_rdata  input 80: bytes PC..PC+9, little-endian; byte k = bits [8k+7:8k].
- mem_error  input 1: address fault; qualified by mem_ready.
- instr_valid  output 1: decoded fields valid.
- icode, ifun  output 4 each: byte0 [7:4] and [3:0].
- rA, rB  output 4 each: byte1 [7:4] and [3:0]; 4'hF when not present.
- valC  output 64: constant or displacement; 0 when not present.
- valP  output 64: pc + instruction length.
- pc  output 64: current fetch PC.
- pc_next_valid  input 1: consumer supplies the next PC.
- pc_next  input 64: next PC value.
- stat  output 2: AOK=0, HLT=1, ADR=2, INS=3.

Function
REQ-003 The FSM SHALL have four states: IDLE, REQ, HOLD, HALTED.
REQ-004 IDLE: when start=1, the FSM SHALL move to REQ on the next edge.
REQ-005 REQ: mem_req SHALL be 1 and mem_addr SHALL equal pc, both held stable until mem_ready=1.
REQ-006 REQ with mem_ready=1: the block SHALL register the decoded fields and move to HOLD, so instr_valid=1 on the following cycle (one-cycle latency from mem_ready).
REQ-007 Instruction length SHALL be:
- 1 for icode 0, 1, 9;
- 2 for icode 2, 6, A, B;
- 9 for icode 7, 8;
- 10 for icode 3, 4, 5.
REQ-008 valC SHALL be:
- bytes[9:2] for icode 3, 4, 5;
- bytes[8:1] for icode 7, 8;
- 0 otherwise.
REQ-009 valP SHALL be pc + length, computed modulo 2^64 (wrap-around allowed).
REQ-010 Instruction validity rules:
- icode > B is invalid.
- For icode 2 or 7, ifun > 6 is invalid.
- For icode 6, ifun > 3 is invalid.
- For all other icodes, ifun != 0 is invalid.
- Any invalid case SHALL set stat=INS.
REQ-011 mem_error=1 with mem_ready=1 SHALL set stat=ADR and SHALL take priority over INS and HLT.
REQ-012 icode=0 with no error SHALL set stat=HLT.
REQ-013 If stat != AOK, the FSM SHALL go to HALTED after one HOLD cycle with instr_valid=1.
REQ-014 HALTED SHALL be sticky until rst: instr_valid=0, mem_req=0, stat and pc held.
REQ-015 HOLD with stat=AOK: outputs SHALL stay stable until pc_next_valid=1; then pc<=pc_next and the FSM moves to REQ.
REQ-016 pc_next_valid SHALL be ignored outside HOLD; start SHALL be ignored outside IDLE.
REQ-017 mem_ready SHALL be ignored outside REQ.

Reset
REQ-018 rst SHALL asynchronously force:
- state=IDLE, pc=0;
- mem_req=0, instr_valid=0, stat=AOK;
- icode=ifun=0, rA=rB=F, valC=0, valP=0.
REQ-019 rst asserted mid-request SHALL drop mem_req immediately; rst SHALL win over all simultaneous inputs.

Structure
REQ-020 A shared package y86_pkg SHALL hold the icode constants (HALT..POPQ), the stat encoding, the FSM state type and the register ID NONE=4'hF.
REQ-021 Length, valC extraction and validity SHALL live in one combinational sub-module, y86_instr_split; fetch_ctrl SHALL hold only the FSM and registers.

Verification
REQ-022 Directed scenarios the bench SHALL cover:
- rst, then start; in REQ, mem_ready with byte0=10 (nop) -> instr_valid next cycle, icode=1, valP=1, stat=AOK.
- pc=0x100, irmovq bytes 30 F2 then 08 07..00 -> rB=2, valC=0x0001020304050607, valP=0x10A.
- In HOLD, pc_next_valid with pc_next=0x40 -> mem_addr=0x40 and mem_req=1 next cycle; mem_ready delayed 3 cycles -> mem_addr stable throughout.
- Byte0=0x65 -> stat=INS, HALTED; later pc_next_valid and start -> no effect, mem_req stays 0.
- mem_ready with mem_error=1 and byte0=0x00 -> stat=ADR (not HLT).
- pc=0xFFFF_FFFF_FFFF_FFFF, nop -> valP=0; rst asserted during REQ -> mem_req=0 in the same cycle, state=IDLE.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 fetch definitions: instruction codes, status encoding,
// fetch FSM states and the "no register" identifier.
package y86_pkg;

   // Instruction codes (byte0[7:4])
   localparam logic [3:0] HALT   = 4'h0;
   localparam logic [3:0] NOP    = 4'h1;
   localparam logic [3:0] RRMOVQ = 4'h2;
   localparam logic [3:0] IRMOVQ = 4'h3;
   localparam logic [3:0] RMMOVQ = 4'h4;
   localparam logic [3:0] MRMOVQ = 4'h5;
   localparam logic [3:0] OPQ    = 4'h6;
   localparam logic [3:0] JXX    = 4'h7;
   localparam logic [3:0] CALL   = 4'h8;
   localparam logic [3:0] RET    = 4'h9;
   localparam logic [3:0] PUSHQ  = 4'hA;
   localparam logic [3:0] POPQ   = 4'hB;

   // Register ID meaning "no register operand"
   localparam logic [3:0] NONE = 4'hF;

   // Processor status reported with each fetched instruction
   typedef enum logic [1:0] {
      AOK = 2'd0,
      HLT = 2'd1,
      ADR = 2'd2,
      INS = 2'd3
   } stat_t;

   // Fetch controller states
   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_REQ    = 2'd1,
      S_HOLD   = 2'd2,
      S_HALTED = 2'd3
   } state_t;

endpackage

// File: rtl/y86_instr_split.sv
// Purely combinational splitter: pulls icode/ifun/registers/constant out of
// the 10 raw instruction bytes, works out the length-based valP and flags
// encodings that are not legal Y86-64 instructions.
module y86_instr_split
   import y86_pkg::*;
(
   input  logic [79:0] i_bytes,
   input  logic [63:0] i_pc,
   output logic [3:0]  o_icode,
   output logic [3:0]  o_ifun,
   output logic [3:0]  o_ra,
   output logic [3:0]  o_rb,
   output logic [63:0] o_valc,
   output logic [63:0] o_valp,
   output logic        o_invalid
);

   logic [3:0] w_len;
   logic       w_has_regs;

   assign o_icode = i_bytes[7:4];
   assign o_ifun  = i_bytes[3:0];

   // Decode length, operand presence, constant and legality from icode/ifun
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      w_len      = 4'd1;
      w_has_regs = 1'b0;
      o_valc     = '0;
      o_invalid  = 1'b0;
      case (o_icode)
         HALT, NOP, RET: begin
            o_invalid = (o_ifun != 4'h0);
         end
         RRMOVQ: begin
            w_len      = 4'd2;
            w_has_regs = 1'b1;
            o_invalid  = (o_ifun > 4'h6);
         end
         OPQ: begin
            w_len      = 4'd2;
            w_has_regs = 1'b1;
            o_invalid  = (o_ifun > 4'h3);
         end
         PUSHQ, POPQ: begin
            w_len      = 4'd2;
            w_has_regs = 1'b1;
            o_invalid  = (o_ifun != 4'h0);
         end
         JXX: begin
            w_len     = 4'd9;
            o_valc    = i_bytes[71:8];
            o_invalid = (o_ifun > 4'h6);
         end
         CALL: begin
            w_len     = 4'd9;
            o_valc    = i_bytes[71:8];
            o_invalid = (o_ifun != 4'h0);
         end
         IRMOVQ, RMMOVQ, MRMOVQ: begin
            w_len      = 4'd10;
            w_has_regs = 1'b1;
            o_valc     = i_bytes[79:16];
            o_invalid  = (o_ifun != 4'h0);
         end
         default: begin
            o_invalid = 1'b1;
         end
      endcase
   end

   assign o_ra   = w_has_regs ? i_bytes[15:12] : NONE;
   assign o_rb   = w_has_regs ? i_bytes[11:8]  : NONE;
   // Wraps naturally modulo 2^64
   assign o_valp = i_pc + {60'd0, w_len};

endmodule

// File: rtl/fetch_ctrl.sv
// Y86-64 instruction fetch controller: requests the instruction at pc,
// registers the decoded fields one cycle after mem_ready, holds them until
// the consumer supplies the next pc, and parks in HALTED on any non-AOK status.
module fetch_ctrl
   import y86_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic        mem_req,
   output logic [63:0] mem_addr,
   input  logic        mem_ready,
   input  logic [79:0] mem_rdata,
   input  logic        mem_error,
   output logic        instr_valid,
   output logic [3:0]  icode,
   output logic [3:0]  ifun,
   output logic [3:0]  rA,
   output logic [3:0]  rB,
   output logic [63:0] valC,
   output logic [63:0] valP,
   output logic [63:0] pc,
   input  logic        pc_next_valid,
   input  logic [63:0] pc_next,
   output logic [1:0]  stat
);

   state_t      r_state;
   state_t      w_next_state;
   logic        w_capture;
   logic        w_advance;
   stat_t       w_stat_new;
   stat_t       r_stat;
   logic [63:0] r_pc;
   logic [3:0]  r_icode, r_ifun, r_ra, r_rb;
   logic [63:0] r_valc, r_valp;

   logic [3:0]  w_icode, w_ifun, w_ra, w_rb;
   logic [63:0] w_valc, w_valp;
   logic        w_invalid;

   y86_instr_split u_split (
      .i_bytes   (mem_rdata),
      .i_pc      (r_pc),
      .o_icode   (w_icode),
      .o_ifun    (w_ifun),
      .o_ra      (w_ra),
      .o_rb      (w_rb),
      .o_valc    (w_valc),
      .o_valp    (w_valp),
      .o_invalid (w_invalid)
   );

   // Status priority: address fault beats illegal encoding beats halt
   always_comb begin
      w_stat_new = AOK;
      if (mem_error)            w_stat_new = ADR;
      else if (w_invalid)       w_stat_new = INS;
      else if (w_icode == HALT) w_stat_new = HLT;
   end

   // State register; async reset drops mem_req/instr_valid immediately
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next_state;
   end

   // Next-state and state-decoded outputs
   always_comb begin
      w_next_state = r_state;
      w_capture    = 1'b0;
      w_advance    = 1'b0;
      mem_req      = 1'b0;
      instr_valid  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) w_next_state = S_REQ;
         end
         S_REQ: begin
            mem_req = 1'b1;
            if (mem_ready) begin
               w_capture    = 1'b1;
               w_next_state = S_HOLD;
            end
         end
         S_HOLD: begin
            instr_valid = 1'b1;
            if (r_stat != AOK) begin
               w_next_state = S_HALTED;
            end else if (pc_next_valid) begin
               w_advance    = 1'b1;
               w_next_state = S_REQ;
            end
         end
         default: begin
            w_next_state = S_HALTED;
         end
      endcase
   end

   // Decoded-field, status and pc registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc    <= '0;
         r_stat  <= AOK;
         r_icode <= HALT;
         r_ifun  <= 4'h0;
         r_ra    <= NONE;
         r_rb    <= NONE;
         r_valc  <= '0;
         r_valp  <= '0;
      end else begin
         if (w_capture) begin
            r_stat  <= w_stat_new;
            r_icode <= w_icode;
            r_ifun  <= w_ifun;
            r_ra    <= w_ra;
            r_rb    <= w_rb;
            r_valc  <= w_valc;
            r_valp  <= w_valp;
         end
         if (w_advance) r_pc <= pc_next;
      end
   end

   assign mem_addr = r_pc;
   assign pc       = r_pc;
   assign stat     = r_stat;
   assign icode    = r_icode;
   assign ifun     = r_ifun;
   assign rA       = r_ra;
   assign rB       = r_rb;
   assign valC     = r_valc;
   assign valP     = r_valp;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: linear scenario sequence with hand-computed
// expected values checked by immediate assertions.
module tb_fetch_ctrl;

   logic        clk;
   logic        rst;
   logic        start;
   logic        mem_req;
   logic [63:0] mem_addr;
   logic        mem_ready;
   logic [79:0] mem_rdata;
   logic        mem_error;
   logic        instr_valid;
   logic [3:0]  icode, ifun, rA, rB;
   logic [63:0] valC, valP, pc;
   logic        pc_next_valid;
   logic [63:0] pc_next;
   logic [1:0]  stat;

   int n_chk = 0;
   int n_err = 0;

   fetch_ctrl dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .mem_req       (mem_req),
      .mem_addr      (mem_addr),
      .mem_ready     (mem_ready),
      .mem_rdata     (mem_rdata),
      .mem_error     (mem_error),
      .instr_valid   (instr_valid),
      .icode         (icode),
      .ifun          (ifun),
      .rA            (rA),
      .rB            (rB),
      .valC          (valC),
      .valP          (valP),
      .pc            (pc),
      .pc_next_valid (pc_next_valid),
      .pc_next       (pc_next),
      .stat          (stat)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to just after the next rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic load(input logic [79:0] bytes, input logic err);
      mem_ready = 1'b1;
      mem_rdata = bytes;
      mem_error = err;
      step();
      mem_ready = 1'b0;
      mem_error = 1'b0;
   endtask

   task automatic next_pc(input logic [63:0] addr);
      pc_next_valid = 1'b1;
      pc_next       = addr;
      step();
      pc_next_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
      mem_error = 1'b0; pc_next_valid = 1'b0; pc_next = '0;
      step(); step();

      // Reset values
      chk("rst_mem_req", mem_req, 0);
      chk("rst_instr_valid", instr_valid, 0);
      chk("rst_stat", stat, 0);
      chk("rst_icode", icode, 0);
      chk("rst_ifun", ifun, 0);
      chk("rst_rA", rA, 4'hF);
      chk("rst_rB", rB, 4'hF);
      chk("rst_valC", valC, 0);
      chk("rst_valP", valP, 0);
      chk("rst_pc", pc, 0);

      // start -> REQ, nop fetched at pc 0
      rst = 1'b0;
      step();
      chk("idle_no_req", mem_req, 0);
      start = 1'b1; step(); start = 1'b0;
      chk("req_mem_req", mem_req, 1);
      chk("req_addr", mem_addr, 0);
      chk("req_not_valid", instr_valid, 0);
      load(80'h10, 1'b0);
      chk("nop_valid", instr_valid, 1);
      chk("nop_icode", icode, 1);
      chk("nop_valP", valP, 1);
      chk("nop_stat", stat, 0);
      chk("nop_rA", rA, 4'hF);
      chk("hold_no_req", mem_req, 0);
      mem_ready = 1'b1; mem_rdata = 80'h30; step(); mem_ready = 1'b0;
      chk("hold_stable_valid", instr_valid, 1);
      chk("hold_ignores_ready", icode, 1);

      // irmovq at 0x100
      next_pc(64'h100);
      chk("irm_req", mem_req, 1);
      chk("irm_addr", mem_addr, 64'h100);
      load(80'h0001020304050607F230, 1'b0);
      chk("irm_icode", icode, 3);
      chk("irm_rA", rA, 4'hF);
      chk("irm_rB", rB, 2);
      chk("irm_valC", valC, 64'h0001020304050607);
      chk("irm_valP", valP, 64'h10A);
      chk("irm_stat", stat, 0);

      // Redirect to 0x40, memory slow for three cycles
      next_pc(64'h40);
      chk("redir_req", mem_req, 1);
      chk("redir_addr", mem_addr, 64'h40);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("wait_req", mem_req, 1);
         chk("wait_addr", mem_addr, 64'h40);
      end
      load({8'h00, 64'h1122334455667788, 8'h70}, 1'b0);
      chk("jmp_icode", icode, 7);
      chk("jmp_valC", valC, 64'h1122334455667788);
      chk("jmp_valP", valP, 64'h49);
      chk("jmp_rB", rB, 4'hF);

      // opq addq %rcx,%rdx at 0x200
      next_pc(64'h200);
      load(80'h1260, 1'b0);
      chk("opq_rA", rA, 1);
      chk("opq_rB", rB, 2);
      chk("opq_valC", valC, 0);
      chk("opq_valP", valP, 64'h202);
      chk("opq_stat", stat, 0);

      // Illegal opq function -> INS -> HALTED
      next_pc(64'h300);
      load(80'h65, 1'b0);
      chk("ins_valid", instr_valid, 1);
      chk("ins_stat", stat, 3);
      step();
      chk("halt_valid", instr_valid, 0);
      chk("halt_stat", stat, 3);
      pc_next_valid = 1'b1; pc_next = 64'h999; start = 1'b1; mem_ready = 1'b1;
      step(); step(); step();
      pc_next_valid = 1'b0; start = 1'b0; mem_ready = 1'b0;
      chk("halt_no_req", mem_req, 0);
      chk("halt_pc", pc, 64'h300);
      chk("halt_stat_sticky", stat, 3);
      chk("halt_valid_sticky", instr_valid, 0);

      // Address fault beats HLT
      rst = 1'b1; step(); rst = 1'b0;
      chk("rst2_stat", stat, 0);
      start = 1'b1; step(); start = 1'b0;
      load(80'h00, 1'b1);
      chk("adr_stat", stat, 2);
      chk("adr_valid", instr_valid, 1);
      step();
      chk("adr_halted", instr_valid, 0);
      chk("adr_no_req", mem_req, 0);

      // valP wrap at top of address space, then reset mid-request
      rst = 1'b1; step(); rst = 1'b0;
      start = 1'b1; step(); start = 1'b0;
      load(80'h10, 1'b0);
      next_pc(64'hFFFF_FFFF_FFFF_FFFF);
      chk("wrap_addr", mem_addr, 64'hFFFF_FFFF_FFFF_FFFF);
      load(80'h10, 1'b0);
      chk("wrap_valP", valP, 0);
      chk("wrap_stat", stat, 0);
      next_pc(64'h5);
      chk("pre_rst_req", mem_req, 1);
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_req", mem_req, 0);
      chk("async_rst_pc", pc, 0);
      chk("async_rst_valP", valP, 0);
      start = 1'b1; mem_ready = 1'b1; pc_next_valid = 1'b1;
      step();
      chk("rst_wins", mem_req, 0);
      rst = 1'b0; start = 1'b0; mem_ready = 1'b0; pc_next_valid = 1'b0;
      step();
      chk("post_rst_idle", mem_req, 0);
      start = 1'b1; step(); start = 1'b0;
      chk("post_rst_start", mem_req, 1);
      chk("post_rst_addr", mem_addr, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
